sram_rw_port_arbiter: RTL

- Shares the RW port (port 0) of the 32x256 byte-masked 1RW1R SRAM macro between two requesters, A and B.
- Grants one requester per cycle with round-robin arbitration. Registers the SRAM command, captures read data and routes each read response to the requester that issued it.
- After reset, a built-in sequencer zero-fills the array before any requester is granted.
- Sits between the core/DMA bus adapters and the macro; the read-only port 1 is not handled by this block.

---
 rtl/sram_rw_port_arbiter.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/sram_rw_port_arbiter.sv
// Round-robin arbiter for the RW port of the 32x256 byte-masked SRAM macro.
// A post-reset sequencer zero-fills the array before requesters are served.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_INIT | zero-fill sequencer owns the port, one write per cycle
// ST_RUN  | round-robin arbitration between requesters A and B
module sram_rw_port_arbiter #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_WMASKS = 4,
  parameter bit INIT_EN    = 1'b1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,

  input  logic                  a_req_i,
  input  logic                  a_we_i,
  input  logic [NUM_WMASKS-1:0] a_be_i,
  input  logic [ADDR_WIDTH-1:0] a_addr_i,
  input  logic [DATA_WIDTH-1:0] a_wdata_i,
  output logic                  a_gnt_o,
  output logic                  a_rvalid_o,
  output logic [DATA_WIDTH-1:0] a_rdata_o,

  input  logic                  b_req_i,
  input  logic                  b_we_i,
  input  logic [NUM_WMASKS-1:0] b_be_i,
  input  logic [ADDR_WIDTH-1:0] b_addr_i,
  input  logic [DATA_WIDTH-1:0] b_wdata_i,
  output logic                  b_gnt_o,
  output logic                  b_rvalid_o,
  output logic [DATA_WIDTH-1:0] b_rdata_o,

  output logic                  init_done_o,

  output logic                  sram_csb0_o,
  output logic                  sram_web0_o,
  output logic [NUM_WMASKS-1:0] sram_wmask0_o,
  output logic [ADDR_WIDTH-1:0] sram_addr0_o,
  output logic [DATA_WIDTH-1:0] sram_din0_o,
  input  logic [DATA_WIDTH-1:0] sram_dout0_i
);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] init_cnt;
  logic                  rr_b_first;
  logic                  run_en;

  logic                  xfer_b;
  logic                  xfer_we;
  logic [NUM_WMASKS-1:0] xfer_be;
  logic [ADDR_WIDTH-1:0] xfer_addr;
  logic [DATA_WIDTH-1:0] xfer_wdata;
  logic                  any_gnt;
  logic                  issue;
  logic                  issue_rd;

  // Owner/is-read tags for the two cycles between grant and data capture.
  logic [1:0]            pipe_vld;
  logic [1:0]            pipe_b;

  // init_done_o lags the last init write by one cycle; grants wait for it.
  assign run_en  = (state == ST_RUN) && init_done_o;
  assign a_gnt_o = run_en && a_req_i && (!b_req_i || !rr_b_first);
  assign b_gnt_o = run_en && b_req_i && (!a_req_i ||  rr_b_first);
  assign any_gnt = a_gnt_o || b_gnt_o;

  always_comb begin
    xfer_b     = b_gnt_o;
    xfer_we    = a_we_i;
    xfer_be    = a_be_i;
    xfer_addr  = a_addr_i;
    xfer_wdata = a_wdata_i;
    if (b_gnt_o) begin
      xfer_we    = b_we_i;
      xfer_be    = b_be_i;
      xfer_addr  = b_addr_i;
      xfer_wdata = b_wdata_i;
    end
  end

  // A write with no byte enables is accepted but never reaches the macro.
  assign issue    = any_gnt && (!xfer_we || (|xfer_be));
  assign issue_rd = issue && !xfer_we;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state         <= INIT_EN ? ST_INIT : ST_RUN;
      init_done_o   <= !INIT_EN;
      init_cnt      <= '0;
      rr_b_first    <= 1'b0;
      sram_csb0_o   <= 1'b1;
      sram_web0_o   <= 1'b1;
      sram_wmask0_o <= '0;
      sram_addr0_o  <= '0;
      sram_din0_o   <= '0;
      pipe_vld      <= '0;
      pipe_b        <= '0;
      a_rvalid_o    <= 1'b0;
      b_rvalid_o    <= 1'b0;
      a_rdata_o     <= '0;
      b_rdata_o     <= '0;
    end else begin
      sram_csb0_o <= 1'b1;
      case (state)
        ST_INIT: begin
          sram_csb0_o   <= 1'b0;
          sram_web0_o   <= 1'b0;
          sram_wmask0_o <= '1;
          sram_addr0_o  <= init_cnt;
          sram_din0_o   <= '0;
          init_cnt      <= init_cnt + 1'b1;
          if (init_cnt == '1) state <= ST_RUN;
        end
        ST_RUN: begin
          init_done_o <= 1'b1;
          if (any_gnt) rr_b_first <= a_gnt_o;
          if (issue) begin
            sram_csb0_o   <= 1'b0;
            sram_web0_o   <= !xfer_we;
            sram_wmask0_o <= xfer_we ? xfer_be : '0;
            sram_addr0_o  <= xfer_addr;
            sram_din0_o   <= xfer_wdata;
          end
        end
      endcase

      pipe_vld   <= {pipe_vld[0], issue_rd};
      pipe_b     <= {pipe_b[0], xfer_b};
      a_rvalid_o <= pipe_vld[1] && !pipe_b[1];
      b_rvalid_o <= pipe_vld[1] &&  pipe_b[1];
      if (pipe_vld[1] && !pipe_b[1]) a_rdata_o <= sram_dout0_i;
      if (pipe_vld[1] &&  pipe_b[1]) b_rdata_o <= sram_dout0_i;
    end
  end

endmodule
